// File: rtl/nmr_pulse_table_sequencer.sv
// Table-driven NMR pulse sequencer: replays n_pulses {on, gap, phase} entries n_reps times,
// driving the RF gate/phase switch and strobing acq_trig at the end of each repetition.
module nmr_pulse_table_sequencer #(
   parameter int unsigned TICK_DIV = 125,
   parameter int unsigned TICK_W   = 8,
   parameter int unsigned N_PULSES = 8,
   parameter int unsigned IDX_W    = 3,
   parameter int unsigned TIME_W   = 32,
   parameter int unsigned PHASE_W  = 2,
   parameter int unsigned REP_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic               cfg_we,
   input  logic [IDX_W-1:0]   cfg_addr,
   input  logic [TIME_W-1:0]  cfg_len,
   input  logic [TIME_W-1:0]  cfg_gap,
   input  logic [PHASE_W-1:0] cfg_phase,
   input  logic [IDX_W:0]     n_pulses,
   input  logic [REP_W-1:0]   n_reps,
   input  logic               ext_gate_in,
   output logic               busy,
   output logic               done,
   output logic               acq_trig,
   output logic [IDX_W-1:0]   pulse_idx,
   output logic [PHASE_W-1:0] phase_out,
   output logic               pulse_on_out,
   output logic               pulse_on_outn
);

   typedef enum logic [1:0] {StIdle, StOn, StOff, StFin} state_e;

   localparam logic [TICK_W-1:0] DIV_RELOAD = TICK_W'(TICK_DIV - 1);

   state_e             state;
   logic [TICK_W-1:0]  div;
   logic [TIME_W-1:0]  seg;
   logic [REP_W-1:0]   rep;
   logic [IDX_W:0]     np;

   logic [TIME_W-1:0]  len_tab [N_PULSES];
   logic [TIME_W-1:0]  gap_tab [N_PULSES];
   logic [PHASE_W-1:0] ph_tab  [N_PULSES];

   logic               seg_end;
   logic               last_idx;
   logic               cfg_ok;
   logic [IDX_W-1:0]   next_idx;

   // A zero-length segment ends on its first cycle; otherwise on the tick that sees seg==1.
   assign seg_end  = (seg == '0) || ((div == '0) && (seg == TIME_W'(1)));
   assign last_idx = ({1'b0, pulse_idx} == (np - (IDX_W + 1)'(1)));
   assign next_idx = pulse_idx + IDX_W'(1);
   assign cfg_ok   = cfg_we && (state == StIdle) &&
                     ({1'b0, cfg_addr} < (IDX_W + 1)'(N_PULSES));

   always_ff @(posedge clk) begin
      if (cfg_ok) begin
         len_tab[cfg_addr] <= cfg_len;
         gap_tab[cfg_addr] <= cfg_gap;
         ph_tab[cfg_addr]  <= cfg_phase;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         done      <= 1'b0;
         acq_trig  <= 1'b0;
         pulse_idx <= '0;
         phase_out <= '0;
         div       <= '0;
         seg       <= '0;
         rep       <= '0;
         np        <= '0;
      end else begin
         done     <= 1'b0;
         acq_trig <= 1'b0;
         case (state)
            StIdle: begin
               if (start) begin
                  np        <= n_pulses;
                  rep       <= n_reps;
                  pulse_idx <= '0;
                  if ((n_pulses == '0) || (n_reps == '0)) begin
                     state <= StFin;
                     done  <= 1'b1;
                  end else begin
                     state     <= StOn;
                     div       <= DIV_RELOAD;
                     seg       <= len_tab[0];
                     phase_out <= ph_tab[0];
                  end
               end
            end
            StOn: begin
               if (abort) begin
                  state     <= StIdle;
                  pulse_idx <= '0;
                  phase_out <= '0;
               end else if (seg_end) begin
                  state    <= StOff;
                  div      <= DIV_RELOAD;
                  seg      <= gap_tab[pulse_idx];
                  acq_trig <= last_idx;
               end else if (div == '0) begin
                  div <= DIV_RELOAD;
                  seg <= seg - TIME_W'(1);
               end else begin
                  div <= div - TICK_W'(1);
               end
            end
            StOff: begin
               if (abort) begin
                  state     <= StIdle;
                  pulse_idx <= '0;
                  phase_out <= '0;
               end else if (seg_end) begin
                  if (!last_idx) begin
                     state     <= StOn;
                     div       <= DIV_RELOAD;
                     pulse_idx <= next_idx;
                     seg       <= len_tab[next_idx];
                     phase_out <= ph_tab[next_idx];
                  end else if (rep > REP_W'(1)) begin
                     state     <= StOn;
                     div       <= DIV_RELOAD;
                     rep       <= rep - REP_W'(1);
                     pulse_idx <= '0;
                     seg       <= len_tab[0];
                     phase_out <= ph_tab[0];
                  end else begin
                     state     <= StFin;
                     done      <= 1'b1;
                     pulse_idx <= '0;
                     phase_out <= '0;
                  end
               end else if (div == '0) begin
                  div <= DIV_RELOAD;
                  seg <= seg - TIME_W'(1);
               end else begin
                  div <= div - TICK_W'(1);
               end
            end
            StFin: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

   assign busy          = (state != StIdle);
   assign pulse_on_out  = ((state == StOn) && (seg != '0)) || ext_gate_in;
   assign pulse_on_outn = ~pulse_on_out;

endmodule

// File: tb/tb_nmr_pulse_table_sequencer.sv
// Directed bench for nmr_pulse_table_sequencer with TICK_DIV=4; cycle 1 is the first cycle
// after the edge that accepts start.
module tb_nmr_pulse_table_sequencer;

   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned IDX_W    = 3;
   localparam int unsigned TIME_W   = 32;
   localparam int unsigned PHASE_W  = 2;
   localparam int unsigned REP_W    = 16;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic               cfg_we = 1'b0;
   logic [IDX_W-1:0]   cfg_addr = '0;
   logic [TIME_W-1:0]  cfg_len = '0;
   logic [TIME_W-1:0]  cfg_gap = '0;
   logic [PHASE_W-1:0] cfg_phase = '0;
   logic [IDX_W:0]     n_pulses = '0;
   logic [REP_W-1:0]   n_reps = '0;
   logic               ext_gate_in = 1'b0;
   logic               busy, done, acq_trig, pulse_on_out, pulse_on_outn;
   logic [IDX_W-1:0]   pulse_idx;
   logic [PHASE_W-1:0] phase_out;

   nmr_pulse_table_sequencer #(
      .TICK_DIV (TICK_DIV),
      .TICK_W   (8),
      .N_PULSES (8),
      .IDX_W    (IDX_W),
      .TIME_W   (TIME_W),
      .PHASE_W  (PHASE_W),
      .REP_W    (REP_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .cfg_we        (cfg_we),
      .cfg_addr      (cfg_addr),
      .cfg_len       (cfg_len),
      .cfg_gap       (cfg_gap),
      .cfg_phase     (cfg_phase),
      .n_pulses      (n_pulses),
      .n_reps        (n_reps),
      .ext_gate_in   (ext_gate_in),
      .busy          (busy),
      .done          (done),
      .acq_trig      (acq_trig),
      .pulse_idx     (pulse_idx),
      .phase_out     (phase_out),
      .pulse_on_out  (pulse_on_out),
      .pulse_on_outn (pulse_on_outn)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Per-run statistics gathered by run_seq.
   int first_on, last_on, on_cycles, rises, acq_cnt, acq_first, acq_last;
   int done_cnt, done_cyc, end_cyc, busy_cycles;
   int idx_seq [8];
   int ph_seq  [8];
   int evt_cnt;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_entry(input int addr, input int len, input int gap, input int ph);
      cfg_addr  = IDX_W'(addr);
      cfg_len   = TIME_W'(len);
      cfg_gap   = TIME_W'(gap);
      cfg_phase = PHASE_W'(ph);
      cfg_we    = 1'b1;
      step();
      cfg_we    = 1'b0;
   endtask

   // Start a run and observe it until busy falls. At cycle inj_cyc (0 = never) a table write
   // to entry 0 and a second start are attempted while busy.
   task automatic run_seq(input int np, input int reps, input int inj_cyc);
      bit prev_gate;
      bit finished;
      int c;
      n_pulses = (IDX_W + 1)'(np);
      n_reps   = REP_W'(reps);
      start    = 1'b1;
      step();
      start    = 1'b0;
      first_on = -1; last_on = -1; on_cycles = 0; rises = 0;
      acq_cnt = 0; acq_first = -1; acq_last = -1;
      done_cnt = 0; done_cyc = -1; end_cyc = -1; busy_cycles = 0;
      for (int i = 0; i < 8; i++) begin
         idx_seq[i] = -1;
         ph_seq[i]  = -1;
      end
      prev_gate = 1'b0;
      finished  = 1'b0;
      c = 1;
      while (!finished && c < 500) begin
         if (pulse_on_out) begin
            if (first_on < 0) first_on = c;
            last_on = c;
            on_cycles++;
            if (!prev_gate) begin
               if (rises < 8) begin
                  idx_seq[rises] = int'(pulse_idx);
                  ph_seq[rises]  = int'(phase_out);
               end
               rises++;
            end
         end
         prev_gate = pulse_on_out;
         if (acq_trig) begin
            if (acq_first < 0) acq_first = c;
            acq_last = c;
            acq_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = c;
         end
         if (!busy) begin
            finished = 1'b1;
            end_cyc  = c;
         end else begin
            busy_cycles++;
            if (c == inj_cyc) begin
               cfg_addr  = '0;
               cfg_len   = TIME_W'(1);
               cfg_gap   = TIME_W'(1);
               cfg_phase = PHASE_W'(3);
               cfg_we    = 1'b1;
               start     = 1'b1;
            end
            step();
            cfg_we = 1'b0;
            start  = 1'b0;
            c++;
         end
      end
      check_eq("run_terminates", longint'(finished), 1);
   endtask

   initial begin
      repeat (3) step();
      rst = 1'b0;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_acq", acq_trig, 0);
      check_eq("rst_idx", pulse_idx, 0);
      check_eq("rst_phase", phase_out, 0);
      check_eq("rst_gate", pulse_on_out, 0);
      check_eq("rst_gaten", pulse_on_outn, 1);

      // T1: single pulse, len 2 / gap 3 ticks
      write_entry(0, 2, 3, 1);
      run_seq(1, 1, 0);
      check_eq("t1_first_on", first_on, 1);
      check_eq("t1_last_on", last_on, 8);
      check_eq("t1_on_cycles", on_cycles, 8);
      check_eq("t1_phase", ph_seq[0], 1);
      check_eq("t1_acq_cyc", acq_first, 9);
      check_eq("t1_acq_cnt", acq_cnt, 1);
      check_eq("t1_done_cyc", done_cyc, 21);
      check_eq("t1_done_cnt", done_cnt, 1);
      check_eq("t1_end_cyc", end_cyc, 22);

      // T2: three entries, two repetitions, gap 0 on entry 1
      write_entry(0, 1, 1, 0);
      write_entry(1, 2, 0, 1);
      write_entry(2, 1, 2, 2);
      run_seq(3, 2, 0);
      check_eq("t2_rises", rises, 6);
      check_eq("t2_on_cycles", on_cycles, 32);
      check_eq("t2_last_on", last_on, 50);
      for (int i = 0; i < 6; i++) begin
         check_eq($sformatf("t2_idx%0d", i), idx_seq[i], i % 3);
         check_eq($sformatf("t2_ph%0d", i), ph_seq[i], i % 3);
      end
      check_eq("t2_acq_cnt", acq_cnt, 2);
      check_eq("t2_acq_first", acq_first, 22);
      check_eq("t2_acq_last", acq_last, 51);
      check_eq("t2_done_cnt", done_cnt, 1);
      check_eq("t2_done_cyc", done_cyc, 59);
      check_eq("t2_busy_cycles", busy_cycles, 59);

      // T3: abort during the second ON segment (cycles 9..16)
      n_pulses = 4'd3;
      n_reps   = 16'd1;
      start    = 1'b1;
      step();
      start    = 1'b0;
      repeat (9) step();
      check_eq("t3_gate_before", pulse_on_out, 1);
      check_eq("t3_idx_before", pulse_idx, 1);
      check_eq("t3_phase_before", phase_out, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_eq("t3_gate_after", pulse_on_out, 0);
      check_eq("t3_busy_after", busy, 0);
      check_eq("t3_idx_after", pulse_idx, 0);
      check_eq("t3_phase_after", phase_out, 0);
      evt_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (done || acq_trig || pulse_on_out) evt_cnt++;
         step();
      end
      check_eq("t3_quiet_after_abort", evt_cnt, 0);
      run_seq(3, 1, 0);
      check_eq("t3_restart_idx0", idx_seq[0], 0);
      check_eq("t3_restart_rises", rises, 3);
      check_eq("t3_restart_done", done_cyc, 30);

      // T4: empty table run, and zero repetitions
      run_seq(0, 1, 0);
      check_eq("t4_busy_cycles", busy_cycles, 1);
      check_eq("t4_done_cyc", done_cyc, 1);
      check_eq("t4_on_cycles", on_cycles, 0);
      run_seq(2, 0, 0);
      check_eq("t4_rep0_done_cyc", done_cyc, 1);
      check_eq("t4_rep0_on_cycles", on_cycles, 0);

      // T5: writes and start while busy are ignored
      write_entry(0, 2, 3, 1);
      run_seq(1, 1, 3);
      check_eq("t5_busy_done_cnt", done_cnt, 1);
      check_eq("t5_busy_done_cyc", done_cyc, 21);
      check_eq("t5_busy_phase", ph_seq[0], 1);
      run_seq(1, 1, 0);
      check_eq("t5_next_last_on", last_on, 8);
      check_eq("t5_next_phase", ph_seq[0], 1);
      check_eq("t5_next_done_cyc", done_cyc, 21);

      // T6: zero-length pulse, then external gate in IDLE
      write_entry(0, 0, 1, 2);
      run_seq(1, 1, 0);
      check_eq("t6_on_cycles", on_cycles, 0);
      check_eq("t6_acq_cyc", acq_first, 2);
      check_eq("t6_done_cyc", done_cyc, 6);
      ext_gate_in = 1'b1;
      #1;
      check_eq("t6_ext_gate", pulse_on_out, 1);
      check_eq("t6_ext_gaten", pulse_on_outn, 0);
      ext_gate_in = 1'b0;
      #1;
      check_eq("t6_ext_gate_off", pulse_on_out, 0);

      // Reset mid-sequence drops the gate with no done
      write_entry(0, 2, 3, 1);
      n_pulses = 4'd1;
      n_reps   = 16'd1;
      start    = 1'b1;
      step();
      start    = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("rst_mid_gate", pulse_on_out, 0);
      check_eq("rst_mid_busy", busy, 0);
      check_eq("rst_mid_done", done, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
